// File: rtl/morse_playback_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared Morse encoding constants and the playback state type,
//                used by the playback block and the player-2 decoder stage.
//  Revision    : 1.0  initial release
// ============================================================================
package morse_pkg;

    // Symbol encodings, concatenated MSB-first into a right-aligned word
    localparam logic [1:0] DOT_CODE   = 2'b10;
    localparam logic [3:0] LINE_CODE  = 4'b1110;
    localparam int         CODE_WIDTH = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } playback_state_t;

endpackage : morse_pkg
`default_nettype wire

// File: rtl/morse_playback_unit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : unit_timer
//  Description : Counts clock cycles within one Morse unit. expire flags the
//                last cycle of a unit while enabled; the count then returns
//                to zero so consecutive units abut without a gap.
//  Revision    : 1.0  initial release
// ============================================================================
module unit_timer #(
    parameter int UNIT_TICKS = 25_000_000
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int                 c_CNT_W = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(UNIT_TICKS - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    assign expire = enable && (r_count == c_LAST);

    // Tick counter: cleared on request or on reaching the last tick, never wraps
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (clear || expire) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + c_ONE;
        end
    end

endmodule : unit_timer
`default_nettype wire

// File: rtl/morse_playback.sv
`default_nettype none
// ============================================================================
//  Module      : morse_playback
//  Description : Plays a right-aligned Morse code word onto a single LED /
//                buzzer line, one bit per unit, with start/busy/done
//                handshake and abort. Leading zeros are skipped first.
//  Revision    : 1.0  initial release
// ============================================================================
module morse_playback
    import morse_pkg::*;
#(
    parameter int WIDTH      = CODE_WIDTH,
    parameter int UNIT_TICKS = 25_000_000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] code,
    output logic             led,
    output logic             busy,
    output logic             done
);

    localparam int                  c_BITS_W    = $clog2(WIDTH + 1);
    localparam logic [c_BITS_W-1:0] c_BITS_FULL = c_BITS_W'(WIDTH);
    localparam logic [c_BITS_W-1:0] c_BITS_ONE  = c_BITS_W'(1);

    playback_state_t     r_state;
    playback_state_t     w_state_nxt;
    logic [WIDTH-1:0]    r_sr;
    logic [WIDTH-1:0]    w_sr_nxt;
    logic [c_BITS_W-1:0] r_bits_left;
    logic [c_BITS_W-1:0] w_bits_nxt;
    logic                w_tmr_clear;
    logic                w_tmr_enable;
    logic                w_expire;

    // The unit timer only runs while a bit is being shown
    assign w_tmr_enable = (r_state == ST_PLAY);

    unit_timer #(
        .UNIT_TICKS (UNIT_TICKS)
    ) u_unit_timer (
        .clock  (clock),
        .resetn (resetn),
        .clear  (w_tmr_clear),
        .enable (w_tmr_enable),
        .expire (w_expire)
    );

    // Outputs depend only on registered state and shift register
    assign led  = (r_state == ST_PLAY) && r_sr[WIDTH-1];
    assign busy = (r_state == ST_ALIGN) || (r_state == ST_PLAY);
    assign done = (r_state == ST_DONE);

    // State, shift register and remaining-bit count registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_sr        <= '0;
            r_bits_left <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_bits_left <= w_bits_nxt;
        end
    end

    // Next-state logic: skip leading zeros, then shift one bit out per unit
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_bits_nxt  = r_bits_left;
        w_tmr_clear = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_sr_nxt   = code;
                    w_bits_nxt = c_BITS_FULL;
                    // Nothing to play for an empty word: report completion at once
                    w_state_nxt = (code == '0) ? ST_DONE : ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (!r_sr[WIDTH-1]) begin
                    w_sr_nxt   = {r_sr[WIDTH-2:0], 1'b0};
                    w_bits_nxt = r_bits_left - c_BITS_ONE;
                end else begin
                    w_tmr_clear = 1'b1;
                    w_state_nxt = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    if (r_bits_left == c_BITS_ONE) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_sr_nxt    = {r_sr[WIDTH-2:0], 1'b0};
                        w_bits_nxt  = r_bits_left - c_BITS_ONE;
                        w_tmr_clear = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule : morse_playback
`default_nettype wire

// File: tb/tb_morse_playback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_playback
//  Description : Directed bench for morse_playback with UNIT_TICKS=4.
//                Each playback is traced per cycle (cycle 1 = first cycle
//                after the start edge) and summarised against hand-computed
//                expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_morse_playback;

    localparam int c_WIDTH = 20;
    localparam int c_TICKS = 4;
    localparam int c_MAXC  = 100;

    logic               clock;
    logic               resetn;
    logic               start;
    logic               abort;
    logic [c_WIDTH-1:0] code;
    logic               led;
    logic               busy;
    logic               done;

    int n_checks;
    int n_errors;

    logic led_tr  [0:c_MAXC];
    logic busy_tr [0:c_MAXC];
    logic done_tr [0:c_MAXC];

    typedef struct {
        logic [c_WIDTH-1:0] code;
        int                 done_c;
        int                 busy_n;
        int                 on_n;
        int                 first_on;
        int                 last_on;
    } vec_t;

    vec_t vecs [7];

    morse_playback #(
        .WIDTH      (c_WIDTH),
        .UNIT_TICKS (c_TICKS)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .abort  (abort),
        .code   (code),
        .led    (led),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Start a playback of c and trace outputs for c_MAXC cycles; optional
    // abort, re-start and reset pulses are driven in the named cycles.
    task automatic play(input logic [c_WIDTH-1:0] c, input int abort_at,
                        input int restart_at, input int reset_at);
        @(negedge clock);
        code  = c;
        start = 1'b1;
        abort = 1'b0;
        @(posedge clock);
        for (int cyc = 1; cyc <= c_MAXC; cyc++) begin
            @(negedge clock);
            led_tr[cyc]  = led;
            busy_tr[cyc] = busy;
            done_tr[cyc] = done;
            abort  = (cyc == abort_at);
            start  = (cyc == restart_at);
            resetn = (cyc != reset_at);
            code   = (cyc == restart_at) ? c : ~c;
            @(posedge clock);
        end
        @(negedge clock);
        abort  = 1'b0;
        start  = 1'b0;
        resetn = 1'b1;
    endtask

    // Summaries of the last trace
    function automatic int first_done();
        for (int i = 1; i <= c_MAXC; i++) if (done_tr[i]) return i;
        return 0;
    endfunction

    function automatic int count_done();
        int n = 0;
        for (int i = 1; i <= c_MAXC; i++) if (done_tr[i]) n++;
        return n;
    endfunction

    function automatic int count_busy();
        int n = 0;
        for (int i = 1; i <= c_MAXC; i++) if (busy_tr[i]) n++;
        return n;
    endfunction

    function automatic int count_on();
        int n = 0;
        for (int i = 1; i <= c_MAXC; i++) if (led_tr[i]) n++;
        return n;
    endfunction

    function automatic int first_on();
        for (int i = 1; i <= c_MAXC; i++) if (led_tr[i]) return i;
        return 0;
    endfunction

    function automatic int last_on();
        for (int i = c_MAXC; i >= 1; i--) if (led_tr[i]) return i;
        return 0;
    endfunction

    initial begin
        logic [5:0] pat_a;
        logic [3:0] pat_r;
        int         n_idle;
        int         tail;

        n_checks = 0;
        n_errors = 0;
        resetn   = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        code     = '0;

        //            code        done busy  on first last
        vecs[0] = '{20'h0002E,    40,  39,  16,  16,  35};  // A
        vecs[1] = '{20'h00000,     1,   0,   0,   0,   0};  // empty word
        vecs[2] = '{20'hFFFFF,    82,  81,  80,   2,  81};  // all ones
        vecs[3] = '{20'h0000E,    34,  33,  12,  18,  29};  // T
        vecs[4] = '{20'h80000,    82,  81,   4,   2,   5};  // MSB only
        vecs[5] = '{20'h00001,    25,  24,   4,  21,  24};  // LSB only
        vecs[6] = '{20'h0000A,    34,  33,   8,  18,  29};  // I

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_led",  int'(led),  0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        resetn = 1'b1;

        // Table-driven playbacks
        for (int v = 0; v < 7; v++) begin
            play(vecs[v].code, 0, 0, 0);
            chk($sformatf("v%0d_done_cycle", v), first_done(), vecs[v].done_c);
            chk($sformatf("v%0d_done_pulses", v), count_done(), 1);
            chk($sformatf("v%0d_busy_cycles", v), count_busy(), vecs[v].busy_n);
            chk($sformatf("v%0d_led_on_cycles", v), count_on(), vecs[v].on_n);
            chk($sformatf("v%0d_first_on", v), first_on(), vecs[v].first_on);
            chk($sformatf("v%0d_last_on", v), last_on(), vecs[v].last_on);
        end

        // A with start re-pulsed in cycle 25: exact waveform unchanged
        pat_a = 6'b101110;
        play(20'h0002E, 0, 25, 0);
        for (int c = 16; c <= 39; c++) begin
            chk($sformatf("repulse_led_c%0d", c), int'(led_tr[c]),
                int'(pat_a[5 - (c - 16) / 4]));
        end
        chk("repulse_led_c15", int'(led_tr[15]), 0);
        chk("repulse_led_c40", int'(led_tr[40]), 0);
        chk("repulse_busy_c39", int'(busy_tr[39]), 1);
        chk("repulse_busy_c40", int'(busy_tr[40]), 0);
        chk("repulse_done_cycle", first_done(), 40);
        chk("repulse_done_pulses", count_done(), 1);

        // A aborted in cycle 20, new start accepted in cycle 21
        play(20'h0002E, 20, 21, 0);
        chk("abort_busy_c20", int'(busy_tr[20]), 1);
        chk("abort_busy_c21", int'(busy_tr[21]), 0);
        chk("abort_led_c21",  int'(led_tr[21]), 0);
        chk("abort_done_c21", int'(done_tr[21]), 0);
        chk("abort_busy_c22", int'(busy_tr[22]), 1);
        chk("abort_done_cycle", first_done(), 61);
        chk("abort_done_pulses", count_done(), 1);
        chk("abort_busy_cycles", count_busy(), 59);
        chk("abort_led_on_cycles", count_on(), 20);

        // start and abort together in IDLE: nothing happens
        @(negedge clock);
        code  = 20'h0002E;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start  = 1'b0;
        abort  = 1'b0;
        n_idle = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy || done || led) n_idle++;
            @(negedge clock);
        end
        chk("start_abort_idle_activity", n_idle, 0);

        // Reset in cycle 30 of A: everything quiet from cycle 31
        play(20'h0002E, 0, 0, 30);
        chk("rst_busy_c30", int'(busy_tr[30]), 1);
        chk("rst_busy_cycles", count_busy(), 30);
        chk("rst_done_pulses", count_done(), 0);
        tail = 0;
        for (int c = 31; c <= c_MAXC; c++) begin
            if (led_tr[c] || busy_tr[c] || done_tr[c]) tail++;
        end
        chk("rst_outputs_after", tail, 0);

        // Playback after reset: I = 1,0,1,0 each 4 cycles over 18..33
        pat_r = 4'b1010;
        play(20'h0000A, 0, 0, 0);
        for (int c = 18; c <= 33; c++) begin
            chk($sformatf("post_rst_led_c%0d", c), int'(led_tr[c]),
                int'(pat_r[3 - (c - 18) / 4]));
        end
        chk("post_rst_done_cycle", first_done(), 34);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_morse_playback
`default_nettype wire

// File: doc/morse_playback.md
# morse_playback

Serialises a right-aligned Morse code word (dot = `10`, line = `1110`, concatenated MSB-first) onto a single LED/buzzer output, one bit per time unit. It sits upstream of the player-2 decoder stage: it plays player 1's 20-bit code back so player 2 can see or hear it and re-key it. A start/busy/done handshake lets game control trigger playback and detect completion.

## Interface
- `WIDTH`, 20: code word width; matches the `player1_value` width.
- `UNIT_TICKS`, 25_000_000: clock cycles per Morse unit (0.5 s at 50 MHz); must be ≥ 2.
- `clock`  in  1  system clock; all logic on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  begin playback of `code`; sampled only in IDLE.
- `abort`  in  1  cancel playback; returns to IDLE, no `done` pulse.
- `code`  in  WIDTH  right-aligned encoded word; leading zeros are not played.
- `led`  out  1  Morse output; 1 = tone/light on.
- `busy`  out  1  high in ALIGN and PLAY.
- `done`  out  1  one-cycle pulse after the last bit completes.

## Operation
- States: IDLE, ALIGN, PLAY, DONE.
- IDLE: `led`=0, `busy`=0. On `start`=1 and `abort`=0: latch `code` into shift register `sr`, set `bits_left`=WIDTH, and go to ALIGN; if `code`==0, go straight to DONE instead.
- ALIGN: if `sr[WIDTH-1]`==0, shift `sr` left by 1 and decrement `bits_left`. Otherwise clear the tick counter and go to PLAY. With Z leading zeros, ALIGN lasts Z+1 cycles.
- PLAY: `led` = `sr[WIDTH-1]`. The tick counter counts 0..UNIT_TICKS-1. At UNIT_TICKS-1:
  - if `bits_left`==1, go to DONE;
  - else shift `sr` left, decrement `bits_left`, and clear the tick counter.
- Played bit count = WIDTH−Z. This includes the trailing 0 (inter-symbol gap) of the last symbol.
- DONE: `done`=1 for exactly one cycle, `busy`=0, `led`=0, then go to IDLE.
- `abort`=1 in ALIGN, PLAY or DONE: go to IDLE next cycle with `led`=0. `done` is not asserted in the following cycle.
- `start` outside IDLE is ignored. `code` changes after the start cycle have no effect.
- `start` and `abort` asserted together in IDLE: abort wins and the block stays IDLE.
- Widths: `bits_left` is $clog2(WIDTH+1) bits; the tick counter is $clog2(UNIT_TICKS) bits. No wrap: the counter clears at UNIT_TICKS-1.
- All-ones `code`: Z=0 and WIDTH units are played, all on.

## Timing
- Reset (`resetn`=0 at an edge): state=IDLE, `led`=0, `busy`=0, `done`=0, `sr`=0, counters 0. Reset overrides `start` and `abort`, including mid-playback.
- `led`, `busy`, `done` are decoded from registered state and `sr` only, so they are glitch-free.
- Cycle numbering: `start` sampled at edge E0 → ALIGN in cycle 1. PLAY begins in cycle Z+2. Bit k (k=0 first) is on `led` during cycles Z+2+k·UNIT_TICKS … Z+1+(k+1)·UNIT_TICKS.
- `done` occurs in cycle Z+2+(WIDTH−Z)·UNIT_TICKS. `busy` is high from cycle 1 through the cycle before `done`.
- Zero code: `done` in cycle 1, `busy` never high.
- Back-to-back: `start` is accepted again from the cycle after `done`, i.e. the first IDLE cycle.

## Structure
- Package `morse_pkg`: `DOT_CODE`=2'b10, `LINE_CODE`=4'b1110, `CODE_WIDTH`=20, and a `playback_state_t` enum (IDLE/ALIGN/PLAY/DONE). The decoder stage shares these constants.
- Sub-module `unit_timer` (params `UNIT_TICKS`; ports `clock`, `resetn`, `clear`, `enable`, `expire`): the tick counter. `expire` is high combinationally when count==UNIT_TICKS-1 and `enable`=1.
- FSM, shift register and `bits_left` live in `morse_playback`.

## Test plan
All scenarios use UNIT_TICKS=4, WIDTH=20.
- `code`=20'h0002E ("A", Z=14): `led` = 1,0,1,1,1,0, each held 4 cycles, over cycles 16..39; `done` in cycle 40; `busy` high in cycles 1..39.
- `code`=0: `done` in cycle 1, `led` and `busy` never high.
- `code`=20'hFFFFF: `led`=1 for cycles 2..81, `done` in cycle 82.
- `code`=20'h0002E, `abort` in cycle 20: `led`=0 and state IDLE from cycle 21; no `done`; a new `start` is accepted in cycle 21.
- `start` re-pulsed in cycle 25 of an active playback: ignored and the waveform is unchanged. Also: `start` and `abort` together in IDLE → stays IDLE.
- `resetn`=0 in cycle 30 of playback: all outputs 0 from cycle 31. With `code`=20'h0000A (`10`+`10`), playback after reset gives `led` = 1,0,1,0, each held 4 cycles.
